draw_controller: RTL and testbench

DRAW_CONTROLLER -- requirements
Module: draw_controller

---
 rtl/draw_controller.sv | 270 +++++++++++++++++++++++++++
 tb/tb_draw_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_controller.sv
// Sprite draw controller: serialises clear/player/bullet/enemy jobs into a
// one-pixel-per-cycle erase/draw stream for a 160x120 frame buffer.
module draw_controller #(
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter logic [2:0] PLAYER_COLOUR = 3'b010,
  parameter logic [2:0] BULLET_COLOUR = 3'b111,
  parameter logic [2:0] ENEMY_COLOUR  = 3'b100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       p_move,
  input  logic [7:0] p_x,
  input  logic [6:0] p_y,
  input  logic       b_move,
  input  logic [7:0] b_x,
  input  logic [6:0] b_y,
  input  logic       e_move,
  input  logic [7:0] e_x,
  input  logic [6:0] e_y,
  input  logic [2:0] e_w,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       plot,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, CLEAR} state_e;

  localparam logic [1:0] ChPlayer = 2'd0;
  localparam logic [1:0] ChBullet = 2'd1;
  localparam logic [1:0] ChEnemy  = 2'd2;

  state_e     r_state, w_state_nxt;
  logic       r_pend_clr, w_pend_clr_nxt;
  logic [2:0] r_pend, w_pend_nxt;

  // Snapshot of the job being served
  logic [1:0] r_ch, w_ch_nxt;
  logic [7:0] r_sx, w_sx_nxt;
  logic [6:0] r_sy, w_sy_nxt;
  logic [2:0] r_sw, w_sw_nxt;

  // Shadow: last rectangle drawn per channel
  logic [7:0] r_sh_x [3];
  logic [6:0] r_sh_y [3];
  logic [2:0] r_sh_w [3];
  logic [2:0] r_sh_v;
  logic [7:0] w_sh_x_nxt [3];
  logic [6:0] w_sh_y_nxt [3];
  logic [2:0] w_sh_w_nxt [3];
  logic [2:0] w_sh_v_nxt;

  // Sweep counters are one bit wider than the screen so origin+width never wraps
  logic [8:0] r_cx, w_cx_nxt;
  logic [7:0] r_cy, w_cy_nxt;

  logic [7:0] r_vga_x;
  logic [6:0] r_vga_y;
  logic [2:0] r_vga_colour, w_colour_nxt;
  logic       r_plot, w_plot_nxt;

  logic [8:0] w_ox, w_rw;
  logic [7:0] w_oy, w_rh;
  logic       w_x_end, w_y_end, w_last;
  logic [8:0] w_adv_cx;
  logic [7:0] w_adv_cy;

  logic [1:0] w_sel_ch;
  logic [7:0] w_sel_x;
  logic [6:0] w_sel_y;
  logic [2:0] w_sel_w;

  // Rectangle currently being swept
  always_comb begin
    w_ox = 9'd0;
    w_oy = 8'd0;
    w_rw = 9'd1;
    w_rh = 8'd1;
    case (r_state)
      ERASE: begin
        w_ox = {1'b0, r_sh_x[r_ch]};
        w_oy = {1'b0, r_sh_y[r_ch]};
        w_rw = {6'd0, r_sh_w[r_ch]};
        w_rh = {5'd0, r_sh_w[r_ch]};
      end
      DRAW: begin
        w_ox = {1'b0, r_sx};
        w_oy = {1'b0, r_sy};
        w_rw = {6'd0, r_sw};
        w_rh = {5'd0, r_sw};
      end
      CLEAR: begin
        w_rw = 9'd160;
        w_rh = 8'd120;
      end
      default: ;
    endcase
  end

  assign w_x_end  = (r_cx + 9'd1) >= (w_ox + w_rw);
  assign w_y_end  = (r_cy + 8'd1) >= (w_oy + w_rh);
  assign w_last   = w_x_end && w_y_end;
  assign w_adv_cx = w_x_end ? w_ox : r_cx + 9'd1;
  assign w_adv_cy = w_x_end ? r_cy + 8'd1 : r_cy;

  always_comb begin
    w_sel_ch = ChEnemy;
    w_sel_x  = e_x;
    w_sel_y  = e_y;
    w_sel_w  = e_w;
    if (r_pend[0]) begin
      w_sel_ch = ChPlayer;
      w_sel_x  = p_x;
      w_sel_y  = p_y;
      w_sel_w  = 3'd3;
    end else if (r_pend[1]) begin
      w_sel_ch = ChBullet;
      w_sel_x  = b_x;
      w_sel_y  = b_y;
      w_sel_w  = 3'd1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pend_nxt     = r_pend | {e_move, b_move, p_move};
    w_pend_clr_nxt = r_pend_clr | clear;
    w_ch_nxt       = r_ch;
    w_sx_nxt       = r_sx;
    w_sy_nxt       = r_sy;
    w_sw_nxt       = r_sw;
    w_sh_x_nxt     = r_sh_x;
    w_sh_y_nxt     = r_sh_y;
    w_sh_w_nxt     = r_sh_w;
    w_sh_v_nxt     = r_sh_v;
    w_cx_nxt       = r_cx;
    w_cy_nxt       = r_cy;

    case (r_state)
      IDLE: begin
        if (r_pend_clr) begin
          w_state_nxt    = CLEAR;
          w_pend_clr_nxt = clear;
          w_pend_nxt     = {e_move, b_move, p_move};
          w_sh_v_nxt     = 3'b000;
          w_cx_nxt       = 9'd0;
          w_cy_nxt       = 8'd0;
        end else if (|r_pend) begin
          w_ch_nxt             = w_sel_ch;
          w_sx_nxt             = w_sel_x;
          w_sy_nxt             = w_sel_y;
          w_sw_nxt             = w_sel_w;
          w_pend_nxt[w_sel_ch] = 1'b0;
          if (r_sh_v[w_sel_ch] && (r_sh_w[w_sel_ch] != 3'd0)) begin
            w_state_nxt = ERASE;
            w_cx_nxt    = {1'b0, r_sh_x[w_sel_ch]};
            w_cy_nxt    = {1'b0, r_sh_y[w_sel_ch]};
          end else if (w_sel_w != 3'd0) begin
            w_state_nxt = DRAW;
            w_cx_nxt    = {1'b0, w_sel_x};
            w_cy_nxt    = {1'b0, w_sel_y};
          end else begin
            // Nothing to erase or draw: record the dead sprite and stay idle
            w_sh_x_nxt[w_sel_ch] = w_sel_x;
            w_sh_y_nxt[w_sel_ch] = w_sel_y;
            w_sh_w_nxt[w_sel_ch] = w_sel_w;
            w_sh_v_nxt[w_sel_ch] = 1'b0;
          end
        end
      end
      ERASE: begin
        if (w_last) begin
          if (r_sw != 3'd0) begin
            w_state_nxt = DRAW;
            w_cx_nxt    = {1'b0, r_sx};
            w_cy_nxt    = {1'b0, r_sy};
          end else begin
            w_state_nxt      = IDLE;
            w_sh_x_nxt[r_ch] = r_sx;
            w_sh_y_nxt[r_ch] = r_sy;
            w_sh_w_nxt[r_ch] = r_sw;
            w_sh_v_nxt[r_ch] = 1'b0;
          end
        end else begin
          w_cx_nxt = w_adv_cx;
          w_cy_nxt = w_adv_cy;
        end
      end
      DRAW: begin
        if (w_last) begin
          w_state_nxt      = IDLE;
          w_sh_x_nxt[r_ch] = r_sx;
          w_sh_y_nxt[r_ch] = r_sy;
          w_sh_w_nxt[r_ch] = r_sw;
          w_sh_v_nxt[r_ch] = 1'b1;
        end else begin
          w_cx_nxt = w_adv_cx;
          w_cy_nxt = w_adv_cy;
        end
      end
      CLEAR: begin
        if (w_last) begin
          w_state_nxt = IDLE;
        end else begin
          w_cx_nxt = w_adv_cx;
          w_cy_nxt = w_adv_cy;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output registers carry the pixel addressed by the next counter value
  always_comb begin
    w_plot_nxt   = (w_state_nxt != IDLE) && (w_cx_nxt < 9'd160) && (w_cy_nxt < 8'd120);
    w_colour_nxt = BG_COLOUR;
    if (w_state_nxt == DRAW) begin
      case (w_ch_nxt)
        ChPlayer: w_colour_nxt = PLAYER_COLOUR;
        ChBullet: w_colour_nxt = BULLET_COLOUR;
        default:  w_colour_nxt = ENEMY_COLOUR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_pend_clr   <= 1'b0;
      r_pend       <= 3'b000;
      r_sh_v       <= 3'b000;
      r_vga_x      <= 8'd0;
      r_vga_y      <= 7'd0;
      r_vga_colour <= 3'd0;
      r_plot       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pend_clr <= w_pend_clr_nxt;
      r_pend     <= w_pend_nxt;
      r_sh_v     <= w_sh_v_nxt;
      r_plot     <= w_plot_nxt;
      if (w_plot_nxt) begin
        r_vga_x      <= w_cx_nxt[7:0];
        r_vga_y      <= w_cy_nxt[6:0];
        r_vga_colour <= w_colour_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    r_ch   <= w_ch_nxt;
    r_sx   <= w_sx_nxt;
    r_sy   <= w_sy_nxt;
    r_sw   <= w_sw_nxt;
    r_sh_x <= w_sh_x_nxt;
    r_sh_y <= w_sh_y_nxt;
    r_sh_w <= w_sh_w_nxt;
    r_cx   <= w_cx_nxt;
    r_cy   <= w_cy_nxt;
  end

  assign vga_x      = r_vga_x;
  assign vga_y      = r_vga_y;
  assign vga_colour = r_vga_colour;
  assign plot       = r_plot;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_draw_controller.sv
// Scoreboard bench for draw_controller: directed jobs push expected pixels,
// a negedge monitor pops and compares every plotted pixel.
module tb_draw_controller;

  localparam logic [2:0] BG = 3'b000;
  localparam logic [2:0] PC = 3'b010;
  localparam logic [2:0] BC = 3'b111;
  localparam logic [2:0] EC = 3'b100;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear = 1'b0;
  logic       p_move = 1'b0, b_move = 1'b0, e_move = 1'b0;
  logic [7:0] p_x = '0, b_x = '0, e_x = '0;
  logic [6:0] p_y = '0, b_y = '0, e_y = '0;
  logic [2:0] e_w = '0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot, busy;

  always #5 clk = ~clk;

  draw_controller #(
    .BG_COLOUR    (BG),
    .PLAYER_COLOUR(PC),
    .BULLET_COLOUR(BC),
    .ENEMY_COLOUR (EC)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .clear     (clear),
    .p_move    (p_move),
    .p_x       (p_x),
    .p_y       (p_y),
    .b_move    (b_move),
    .b_x       (b_x),
    .b_y       (b_y),
    .e_move    (e_move),
    .e_x       (e_x),
    .e_y       (e_y),
    .e_w       (e_w),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .plot      (plot),
    .busy      (busy)
  );

  logic [17:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_plots  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push_rect(input int x, input int y, input int w, input logic [2:0] c);
    for (int yy = y; yy < y + w; yy++)
      for (int xx = x; xx < x + w; xx++)
        if (xx < 160 && yy < 120) exp_q.push_back({xx[7:0], yy[6:0], c});
  endtask

  // Monitor
  always @(negedge clk) begin
    logic [17:0] e;
    if (plot === 1'b1) begin
      n_plots++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_plot: got (%0d,%0d,c%0d) required no pixel",
                 vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== e) begin
          n_fail++;
          $display("FAIL pixel: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                   vga_x, vga_y, vga_colour, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
  end

  task automatic pulse_p(input int x, input int y);
    @(negedge clk);
    p_x = x[7:0]; p_y = y[6:0]; p_move = 1'b1;
    @(negedge clk);
    p_move = 1'b0;
  endtask

  task automatic pulse_b(input int x, input int y);
    @(negedge clk);
    b_x = x[7:0]; b_y = y[6:0]; b_move = 1'b1;
    @(negedge clk);
    b_move = 1'b0;
  endtask

  task automatic pulse_e(input int x, input int y, input int w);
    @(negedge clk);
    e_x = x[7:0]; e_y = y[6:0]; e_w = w[2:0]; e_move = 1'b1;
    @(negedge clk);
    e_move = 1'b0;
  endtask

  // Waits for three consecutive idle cycles; reports busy cycles seen
  task automatic wait_idle(input int limit, output int busy_cycles);
    int quiet = 0;
    int cyc = 0;
    busy_cycles = 0;
    while (quiet < 3 && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) begin
        busy_cycles++;
        quiet = 0;
      end else begin
        quiet++;
      end
    end
    if (quiet < 3) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy after %0d cycles required idle", cyc);
    end
  endtask

  initial begin
    int bc, p0;
    bit found;

    repeat (4) @(negedge clk);
    check("rst_plot", plot, 0);
    check("rst_busy", busy, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_plot", plot, 0);

    // First player draw: no erase, first pixel two cycles after the pulse
    p0 = n_plots;
    push_rect(80, 115, 3, PC);
    pulse_p(80, 115);
    check("lat_cycle1_plot", plot, 0);
    @(negedge clk);
    check("lat_cycle2_plot", plot, 1);
    wait_idle(100, bc);
    check("p1_plots", n_plots - p0, 9);
    check("p1_busy_after", busy, 0);

    // Move left by one: erase old then draw new
    p0 = n_plots;
    push_rect(80, 115, 3, BG);
    push_rect(79, 115, 3, PC);
    pulse_p(79, 115);
    wait_idle(100, bc);
    check("p2_plots", n_plots - p0, 18);

    // Simultaneous pulses: player, bullet, enemy order
    p0 = n_plots;
    push_rect(79, 115, 3, BG);
    push_rect(10, 10, 3, PC);
    push_rect(50, 60, 1, BC);
    push_rect(100, 20, 2, EC);
    @(negedge clk);
    p_x = 8'd10;  p_y = 7'd10; p_move = 1'b1;
    b_x = 8'd50;  b_y = 7'd60; b_move = 1'b1;
    e_x = 8'd100; e_y = 7'd20; e_w = 3'd2; e_move = 1'b1;
    @(negedge clk);
    p_move = 1'b0; b_move = 1'b0; e_move = 1'b0;
    wait_idle(200, bc);
    check("multi_plots", n_plots - p0, 23);
    check("multi_q_empty", exp_q.size(), 0);

    // Enemy clipped at the screen corner
    p0 = n_plots;
    push_rect(100, 20, 2, BG);
    push_rect(158, 118, 4, EC);
    pulse_e(158, 118, 4);
    wait_idle(200, bc);
    check("clip_plots", n_plots - p0, 8);
    check("clip_busy_cycles", bc, 20);

    // Clear during an enemy job, plus a bullet latched during the clear
    p0 = n_plots;
    push_rect(158, 118, 4, BG);
    push_rect(30, 40, 3, EC);
    pulse_e(30, 40, 3);
    repeat (4) @(negedge clk);
    push_rect(0, 0, 160, BG);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    repeat (100) @(negedge clk);
    check("clear_busy", busy, 1);
    push_rect(1, 1, 1, BC);
    pulse_b(1, 1);
    wait_idle(25000, bc);
    check("clear_plots", n_plots - p0, 4 + 9 + 19200 + 1);
    check("clear_q_empty", exp_q.size(), 0);

    p0 = n_plots;
    push_rect(5, 6, 3, PC);
    pulse_p(5, 6);
    wait_idle(100, bc);
    check("post_clear_plots", n_plots - p0, 9);

    // Reset in the middle of DRAW
    p0 = n_plots;
    push_rect(5, 6, 3, BG);
    exp_q.push_back({8'd20, 7'd20, PC});
    pulse_p(20, 20);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (plot === 1'b1 && vga_colour === PC) found = 1'b1;
    end
    check("draw_reached", found, 1);
    resetn = 1'b0;
    p_move = 1'b1;
    @(negedge clk);
    p_move = 1'b0;
    check("mid_rst_plot", plot, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_x", vga_x, 0);
    check("mid_rst_y", vga_y, 0);
    check("mid_rst_colour", vga_colour, 0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("no_resume_busy", busy, 0);
    check("no_resume_plots", n_plots - p0, 10);
    check("final_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
